// File: rtl/uart_rx_if.sv
// Processor-side and serial-side signal bundle for the UART receiver.
interface uart_rx_if;
    logic        rx;
    logic        eight;
    logic        pen;
    logic        ohel;
    logic [3:0]  baud;
    logic        read_strobe;
    logic [15:0] port_id;
    logic [7:0]  data;

    modport master (
        output rx, eight, pen, ohel, baud, read_strobe, port_id,
        input  data
    );

    modport slave (
        input  rx, eight, pen, ohel, baud, read_strobe, port_id,
        output data
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 7/8 data bits, optional odd/even parity, one stop bit,
// selectable bit rate, with a two-address read port for byte and status.
module uart_rx (
    input  logic     clk,
    input  logic     reset,
    uart_rx_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e      state_q, state_d;
    logic        rx_meta_q, rxs_q;
    logic        eight_q, pen_q, ohel_q;
    logic [3:0]  baud_q;
    logic [17:0] cnt_q, cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic [7:0]  byte_q;
    logic        rxrdy_q, perr_q, ferr_q, ovf_q;

    logic        cfg_load, frame_done, clear, tick;
    logic [17:0] bit_len, limit;
    logic [7:0]  rx_byte;
    logic        perr_new, ferr_new;

    // Only the low address bit is decoded.
    logic unused_port_id;
    assign unused_port_id = ^bus.port_id[15:1];

    function automatic logic [17:0] bit_time(input logic [3:0] b);
        case (b)
            4'd0:    return 18'd166667;
            4'd1:    return 18'd41667;
            4'd2:    return 18'd20833;
            4'd3:    return 18'd10417;
            4'd4:    return 18'd5208;
            4'd5:    return 18'd2604;
            4'd6:    return 18'd1302;
            4'd7:    return 18'd868;
            4'd8:    return 18'd434;
            4'd9:    return 18'd217;
            4'd10:   return 18'd109;
            default: return 18'd54;
        endcase
    endfunction

    // Start bit is sampled after half a bit time, every later bit after a full one.
    assign bit_len = bit_time(baud_q);
    assign limit   = (state_q == StStart) ? (bit_len >> 1) : bit_len;
    assign tick    = (cnt_q == limit - 18'd1);

    // 7-bit frames leave the data in the upper seven shift positions.
    assign rx_byte  = eight_q ? shift_q : {1'b0, shift_q[7:1]};
    assign perr_new = pen_q & ((^rx_byte ^ par_q) != ohel_q);
    assign ferr_new = ~rxs_q;
    assign clear    = bus.read_strobe & ~bus.port_id[0];

    // Two-flop synchronizer for the asynchronous serial input.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx;
            rxs_q     <= rx_meta_q;
        end
    end

    // FSM and bit-timing state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
        end
    end

    // Next-state: frame sequencing, sampling and shifting.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        cfg_load   = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            StIdle: begin
                cnt_d     = '0;
                bit_cnt_d = '0;
                if (!rxs_q) begin
                    state_d  = StStart;
                    cfg_load = 1'b1;
                end
            end
            StStart: begin
                if (tick) begin
                    cnt_d   = '0;
                    state_d = rxs_q ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 18'd1;
                end
            end
            StData: begin
                if (tick) begin
                    cnt_d     = '0;
                    shift_d   = {rxs_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == (eight_q ? 4'd7 : 4'd6)) begin
                        state_d = pen_q ? StParity : StStop;
                    end
                end else begin
                    cnt_d = cnt_q + 18'd1;
                end
            end
            StParity: begin
                if (tick) begin
                    cnt_d   = '0;
                    par_d   = rxs_q;
                    state_d = StStop;
                end else begin
                    cnt_d = cnt_q + 18'd1;
                end
            end
            StStop: begin
                if (tick) begin
                    cnt_d      = '0;
                    frame_done = 1'b1;
                    state_d    = StIdle;
                end else begin
                    cnt_d = cnt_q + 18'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Frame format is frozen at start detection for the whole frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            eight_q <= 1'b0;
            pen_q   <= 1'b0;
            ohel_q  <= 1'b0;
            baud_q  <= '0;
        end else if (cfg_load) begin
            eight_q <= bus.eight;
            pen_q   <= bus.pen;
            ohel_q  <= bus.ohel;
            baud_q  <= bus.baud;
        end
    end

    // Received byte and status flags; a completing frame wins over a clearing read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_q  <= '0;
            rxrdy_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (frame_done) begin
            byte_q  <= rx_byte;
            rxrdy_q <= 1'b1;
            perr_q  <= perr_new;
            ferr_q  <= ferr_new;
            ovf_q   <= (ovf_q | rxrdy_q) & ~clear;
        end else if (clear) begin
            rxrdy_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end
    end

    assign bus.data = bus.port_id[0] ? {4'b0000, ovf_q, ferr_q, perr_q, rxrdy_q} : byte_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames plus randomized frames checked by a scoreboard.
module tb_uart_rx;

    logic clk = 1'b0;
    logic reset;
    always #10 clk = ~clk;

    uart_rx_if bus ();

    uart_rx dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] rx_byte;
        logic [7:0] status;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    function automatic int unsigned bit_time(input logic [3:0] b);
        case (b)
            4'd0: return 166667;  4'd1: return 41667;  4'd2: return 20833;
            4'd3: return 10417;   4'd4: return 5208;   4'd5: return 2604;
            4'd6: return 1302;    4'd7: return 868;    4'd8: return 434;
            4'd9: return 217;     4'd10: return 109;
            default: return 54;
        endcase
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, got, exp);
        end
    endtask

    task automatic read_port(input logic p, output logic [7:0] v);
        bus.port_id = {15'd0, p};
        #1;
        v = bus.data;
    endtask

    task automatic clear_read();
        @(negedge clk);
        bus.port_id     = 16'd0;
        bus.read_strobe = 1'b1;
        @(negedge clk);
        bus.read_strobe = 1'b0;
        bus.port_id     = 16'd1;
    endtask

    task automatic expect_frame(input string name, input logic [7:0] eb, input logic [7:0] es);
        logic [7:0] v;
        read_port(1'b1, v);
        check({name, " status"}, v, es);
        read_port(1'b0, v);
        check({name, " byte"}, v, eb);
        bus.port_id = 16'd1;
    endtask

    // Serial line driver; parity bit is the one that makes XOR(data,parity) equal ohel.
    task automatic send_frame(input logic [7:0] b, input logic e8, input logic pe,
                              input logic odd, input logic [3:0] bd,
                              input logic par_bad, input logic stop_bit);
        int unsigned n;
        int          nb;
        logic        p;
        n  = bit_time(bd);
        nb = e8 ? 8 : 7;
        @(negedge clk);
        bus.eight = e8;
        bus.pen   = pe;
        bus.ohel  = odd;
        bus.baud  = bd;
        @(negedge clk);
        bus.rx = 1'b0;
        repeat (n) @(negedge clk);
        p = odd;
        for (int i = 0; i < nb; i++) begin
            bus.rx = b[i];
            p      = p ^ b[i];
            repeat (n) @(negedge clk);
        end
        if (pe) begin
            bus.rx = par_bad ? ~p : p;
            repeat (n) @(negedge clk);
        end
        bus.rx = stop_bit;
        repeat (n) @(negedge clk);
        bus.rx = 1'b1;
    endtask

    // Sends an 8N1 frame at baud 11 and strobes a read on its completion edge.
    task automatic frame_with_strobe(input logic [7:0] b, input logic p);
        fork
            send_frame(b, 1'b1, 1'b0, 1'b0, 4'd11, 1'b0, 1'b1);
            begin
                wait (bus.rx == 1'b0);
                repeat (515) @(negedge clk);
                bus.port_id     = {15'd0, p};
                bus.read_strobe = 1'b1;
                @(negedge clk);
                bus.read_strobe = 1'b0;
                bus.port_id     = 16'd1;
            end
        join
        repeat (108) @(negedge clk);
    endtask

    // Scoreboard monitor: whenever rxrdy shows, compare against the oldest expectation.
    initial begin
        exp_t       e;
        logic [7:0] v;
        forever begin
            @(negedge clk);
            if (mon_en && bus.data[0]) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rand unexpected: got status %02h expected none", bus.data);
                    clear_read();
                end else begin
                    e = sb_q.pop_front();
                    check("rand status", bus.data, e.status);
                    read_port(1'b0, v);
                    check("rand byte", v, e.rx_byte);
                    clear_read();
                    read_port(1'b1, v);
                    check("rand clear", v, 8'h00);
                end
            end
        end
    end

    initial begin
        logic [7:0]  v, b, eb;
        logic        e8, pe, od, pb, sbit;
        logic [3:0]  bd;
        int unsigned n, cnt, tmo;

        reset           = 1'b0;
        bus.rx          = 1'b1;
        bus.eight       = 1'b1;
        bus.pen         = 1'b0;
        bus.ohel        = 1'b0;
        bus.baud        = 4'd11;
        bus.read_strobe = 1'b0;
        bus.port_id     = 16'd1;
        repeat (3) @(negedge clk);
        read_port(1'b0, v);
        check("reset byte", v, 8'h00);
        read_port(1'b1, v);
        check("reset status", v, 8'h00);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // 8N1 0xAA with ready latency
        cnt = 0;
        fork
            send_frame(8'hAA, 1'b1, 1'b0, 1'b0, 4'd11, 1'b0, 1'b1);
            begin
                wait (bus.rx == 1'b0);
                bus.port_id = 16'd1;
                while (!bus.data[0] && cnt < 2000) begin
                    @(negedge clk);
                    cnt++;
                end
            end
        join
        checks++;
        if (cnt < 505 || cnt > 525) begin
            errors++;
            $display("FAIL rdy latency: got %0d cycles expected 505..525", cnt);
        end
        expect_frame("aa", 8'hAA, 8'h01);
        clear_read();

        // 7O1 with wrong parity, then clear
        send_frame(8'h55, 1'b0, 1'b1, 1'b1, 4'd11, 1'b1, 1'b1);
        repeat (108) @(negedge clk);
        expect_frame("perr", 8'h55, 8'h03);
        clear_read();
        read_port(1'b1, v);
        check("perr cleared", v, 8'h00);

        // Framing error
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 4'd11, 1'b0, 1'b0);
        repeat (108) @(negedge clk);
        expect_frame("ferr", 8'h3C, 8'h05);
        clear_read();

        // Overrun; status-port strobe on completion edge has no effect
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, 4'd11, 1'b0, 1'b1);
        repeat (108) @(negedge clk);
        frame_with_strobe(8'h22, 1'b1);
        expect_frame("ovf", 8'h22, 8'h09);
        // Clearing read on completion edge loses to the completion
        frame_with_strobe(8'h33, 1'b0);
        expect_frame("clr vs done", 8'h33, 8'h01);
        clear_read();

        // Glitch shorter than half a bit
        @(negedge clk);
        bus.rx = 1'b0;
        repeat (20) @(negedge clk);
        bus.rx = 1'b1;
        repeat (200) @(negedge clk);
        read_port(1'b1, v);
        check("glitch status", v, 8'h00);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 4'd11, 1'b0, 1'b1);
        repeat (108) @(negedge clk);
        expect_frame("after glitch", 8'h5A, 8'h01);

        // Reset during bit 4 aborts the frame and clears everything at once
        fork
            send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 4'd11, 1'b0, 1'b1);
            begin
                wait (bus.rx == 1'b0);
                repeat (5 * 54 + 27) @(negedge clk);
                reset = 1'b0;
                read_port(1'b0, v);
                check("midreset byte", v, 8'h00);
                read_port(1'b1, v);
                check("midreset status", v, 8'h00);
                repeat (3) @(negedge clk);
                reset = 1'b1;
            end
        join
        repeat (108) @(negedge clk);
        expect_frame("aborted", 8'h00, 8'h00);
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 4'd11, 1'b0, 1'b1);
        repeat (108) @(negedge clk);
        expect_frame("after reset", 8'hC3, 8'h01);
        clear_read();

        // Randomized frames through the scoreboard
        bus.port_id = 16'd1;
        @(negedge clk);
        mon_en = 1'b1;
        for (int f = 0; f < 30; f++) begin
            b    = 8'($urandom);
            e8   = 1'($urandom_range(0, 1));
            pe   = 1'($urandom_range(0, 1));
            od   = 1'($urandom_range(0, 1));
            pb   = 1'($urandom_range(0, 1));
            sbit = ($urandom_range(0, 7) != 0);
            bd   = 4'($urandom_range(10, 15));
            n    = bit_time(bd);
            eb   = e8 ? b : {1'b0, b[6:0]};
            sb_q.push_back('{rx_byte: eb, status: {4'b0000, 1'b0, ~sbit, pe & pb, 1'b1}});
            send_frame(b, e8, pe, od, bd, pb, sbit);
            tmo = 0;
            while (sb_q.size() != 0 && tmo < 4 * n) begin
                @(negedge clk);
                tmo++;
            end
            checks++;
            if (sb_q.size() != 0) begin
                errors++;
                $display("FAIL rand timeout: got %0d pending expected 0", sb_q.size());
                sb_q.delete();
            end
            repeat (2 * n) @(negedge clk);
        end
        mon_en = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d pending expected 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
